block_unpad_writer: RTL

BLOCK_UNPAD_WRITER -- requirements
Module: block_unpad_writer

---
 rtl/block_unpad_writer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/block_unpad_writer.sv
// ---------------------------------------------------------------------------
// block_unpad_writer
//
// Takes a stream of 64-bit blocks and writes the first size_i bytes of it
// into a 32-bit-wide message buffer. Each block becomes two word writes:
// the high word (block bytes 0..3) and then the low word (block bytes 4..7).
// Lanes past the end of the message have their byte enables cleared. The
// number of blocks consumed is always floor(size/8)+1. The last block can
// carry zero valid bytes; it is still consumed, but nothing is written.
//
// Ports
//   clk_i        clock; all logic is on its rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      start pulse, sampled only in IDLE
//   size_i       message length in bytes, latched with start_i
//   blk_i        input block, byte 0 at bits 63:56
//   blk_valid_i  block valid
//   blk_ready_o  block ready, high only in WAIT_BLK
//   wr_en_o      buffer write strobe
//   wr_addr_o    32-bit word address
//   wr_data_o    write word; byte address 4*addr+j sits in bits 8j+7:8j
//   wr_be_o      byte enables
//   busy_o       high in every state except IDLE
//   done_o       one-cycle completion pulse
//
// Optional build macro BLOCK_UNPAD_CLEAR_EN:
//   Data lanes whose byte enable is low are driven as zero, and the block
//   register is cleared on entry to DONE. Without the macro, all lanes carry
//   the raw block bytes and the block register keeps its last contents.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i
// WAIT_BLK | blk_ready_o high, waiting for a block handshake
// WR_HI    | write word 2*blk with block bytes 0..3
// WR_LO    | write word 2*blk+1 with block bytes 4..7, then advance
// DONE     | done_o pulse, back to IDLE
// ---------------------------------------------------------------------------
module block_unpad_writer #(
    parameter int DATA_AW  = 7,
    parameter int BLOCK_AW = DATA_AW - 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_AW-1:0]   size_i,
    input  logic [63:0]          blk_i,
    input  logic                 blk_valid_i,
    output logic                 blk_ready_o,
    output logic                 wr_en_o,
    output logic [DATA_AW-3:0]   wr_addr_o,
    output logic [31:0]          wr_data_o,
    output logic [3:0]           wr_be_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BLK = 3'd1,
        S_WR_HI    = 3'd2,
        S_WR_LO    = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_AW-1:0]   size_q, size_d;
    logic [BLOCK_AW:0]    blk_cnt_q, blk_cnt_d;
    logic [63:0]          blk_q, blk_d;

    logic [BLOCK_AW:0]    final_idx;
    logic                 last_blk;

    // Index of the final block: floor(size/8).
    assign final_idx = (BLOCK_AW+1)'(size_q >> 3);
    assign last_blk  = (blk_cnt_q == final_idx);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            size_q    <= '0;
            blk_cnt_q <= '0;
            blk_q     <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            blk_cnt_q <= blk_cnt_d;
            blk_q     <= blk_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        blk_cnt_d = blk_cnt_q;
        blk_d     = blk_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    size_d    = size_i;
                    blk_cnt_d = '0;
                    state_d   = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                if (blk_valid_i) begin
                    blk_d   = blk_i;
                    state_d = S_WR_HI;
                end
            end
            S_WR_HI: begin
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                if (last_blk) begin
                    state_d = S_DONE;
`ifdef BLOCK_UNPAD_CLEAR_EN
                    blk_d   = '0;
`endif
                end else begin
                    state_d = S_WAIT_BLK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    logic                 lo_half;
    logic [DATA_AW+1:0]   byte_base;
    logic [31:0]          half_word;

    always_comb begin
        blk_ready_o = 1'b0;
        wr_en_o     = 1'b0;
        wr_addr_o   = '0;
        wr_data_o   = '0;
        wr_be_o     = '0;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        lo_half     = (state_q == S_WR_LO);
        // Message byte address of lane 0 for the current write.
        byte_base   = (DATA_AW+2)'({blk_cnt_q, lo_half, 2'b00});
        half_word   = lo_half ? blk_q[31:0] : blk_q[63:32];

        case (state_q)
            S_WAIT_BLK: begin
                blk_ready_o = 1'b1;
            end
            S_WR_HI, S_WR_LO: begin
                wr_addr_o = (DATA_AW-2)'({blk_cnt_q, lo_half});
                for (int k = 0; k < 4; k++) begin
                    // Block byte order is big-endian; buffer lanes are little-endian.
                    wr_be_o[k] = ((byte_base + (DATA_AW+2)'(k)) <
                                  (DATA_AW+2)'(size_q));
`ifdef BLOCK_UNPAD_CLEAR_EN
                    wr_data_o[8*k +: 8] = wr_be_o[k] ? half_word[31-8*k -: 8] : 8'h00;
`else
                    wr_data_o[8*k +: 8] = half_word[31-8*k -: 8];
`endif
                end
                wr_en_o = |wr_be_o;
            end
            default: begin
            end
        endcase
    end

endmodule
